// File: rtl/jtag_host_pkg.sv
// Shared encodings for the JTAG host master: command types, FSM states and
// LSB-first TMS fragments (bit 0 is driven on the first TCK).
package jtag_host_pkg;

    localparam int LEN_W = 7;

    typedef enum logic [1:0] {
        CMD_TAP_RESET = 2'd0,
        CMD_IR_SCAN   = 2'd1,
        CMD_DR_SCAN   = 2'd2,
        CMD_RUN_IDLE  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [5:0] TMS_RESET  = 6'b011111;
    localparam logic [3:0] TMS_IR_PRE = 4'b0011;
    localparam logic [2:0] TMS_DR_PRE = 3'b001;
    localparam logic [1:0] TMS_POST   = 2'b01;

endpackage

// File: rtl/jtag_host_master_tck_gen.sv
// TCK divider: CLK_DIV clk cycles per half-period, low phase first. Strobes flag
// the clk edge on which tck rises/falls. i_hold keeps tck low while still timing.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_hold,
    output logic o_tck,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_tck;
    logic          w_wrap;

    assign w_wrap = i_run && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise = w_wrap && !r_phase;
    assign o_fall = w_wrap && r_phase;
    assign o_tck  = r_tck;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_tck   <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            if (w_wrap) begin
                r_phase <= ~r_phase;
                r_tck   <= ~r_phase & ~i_hold;
            end
        end
    end
endmodule

// File: rtl/jtag_host_master.sv
// System-clocked JTAG master: one command at a time, TMS/TDI pre-built as LSB-first
// vectors at accept and shifted out one entry per TCK. Optional o_trst_n via JTAG_HOST_TRST_EN.
module jtag_host_master
    import jtag_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 64,
    parameter int IR_LEN  = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_type,
    input  logic [LEN_W-1:0]   i_cmd_len,
    input  logic [MAX_LEN-1:0] i_cmd_data,
    output logic               o_rsp_valid,
    output logic               o_rsp_err,
    output logic [MAX_LEN-1:0] o_rsp_data,
    output logic               o_busy,
    output logic               o_tck,
    output logic               o_tms,
    output logic               o_tdi,
`ifdef JTAG_HOST_TRST_EN
    output logic               o_trst_n,
`endif
    input  logic               i_tdo
);
    localparam int SEQ_W = MAX_LEN + 6;
    localparam int CNT_W = LEN_W + 1;
    localparam int BIT_W = $clog2(MAX_LEN);

    state_e             r_state;
    cmd_e               r_cmd;
    logic               r_tap_known;
    logic [CNT_W-1:0]   r_left;
    logic [BIT_W-1:0]   r_bit;
    logic [SEQ_W-1:0]   r_tms_sr, r_tdi_sr, r_sh_sr;
    logic               r_tms, r_tdi, r_sh;
    logic [MAX_LEN-1:0] r_rx, r_rsp_data;
    logic               r_rsp_valid, r_rsp_err;
    logic               w_rise, w_fall, w_hold;
    logic [SEQ_W-1:0]   w_tms_v, w_tdi_v, w_sh_v;
    logic [CNT_W-1:0]   w_total;
    logic               w_err, w_empty;
`ifdef JTAG_HOST_TRST_EN
    logic [SEQ_W-1:0]   r_trst_sr, w_trst_v;
    logic               r_trst_n;
    localparam int RESET_TCKS = 8;
    assign o_trst_n = r_trst_n;
    assign w_hold   = ~r_trst_n;
`else
    localparam int RESET_TCKS = 6;
    assign w_hold = 1'b0;
`endif

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_busy      = ~o_cmd_ready;
    assign o_tms       = r_tms;
    assign o_tdi       = r_tdi;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_data  = r_rsp_data;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_run  (r_state == ST_RUN),
        .i_hold (w_hold),
        .o_tck  (o_tck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Per-command TMS/TDI/shift-flag vectors; entry i is driven on TCK i.
    always_comb begin
        w_tms_v = '0;
        w_tdi_v = '0;
        w_sh_v  = '0;
        w_total = '0;
        w_err   = 1'b0;
        w_empty = 1'b0;
`ifdef JTAG_HOST_TRST_EN
        w_trst_v = '0;
`endif
        case (cmd_e'(i_cmd_type))
            CMD_TAP_RESET: begin
`ifdef JTAG_HOST_TRST_EN
                w_tms_v  = SEQ_W'({TMS_RESET, 2'b11});
                w_trst_v = SEQ_W'(2'b11);
`else
                w_tms_v  = SEQ_W'(TMS_RESET);
`endif
                w_total  = CNT_W'(RESET_TCKS);
            end
            CMD_IR_SCAN: begin
                w_sh_v  = SEQ_W'({IR_LEN{1'b1}}) << 4;
                w_tms_v = SEQ_W'(TMS_IR_PRE) | (SEQ_W'(1) << (IR_LEN + 3))
                        | (SEQ_W'(TMS_POST) << (IR_LEN + 4));
                w_tdi_v = SEQ_W'(i_cmd_data[IR_LEN-1:0]) << 4;
                w_total = CNT_W'(IR_LEN + 6);
                w_err   = !r_tap_known;
            end
            CMD_DR_SCAN: begin
                w_sh_v  = ((SEQ_W'(1) << i_cmd_len) - SEQ_W'(1)) << 3;
                w_tms_v = SEQ_W'(TMS_DR_PRE) | (SEQ_W'(1) << (i_cmd_len + 7'd2))
                        | (SEQ_W'(TMS_POST) << (i_cmd_len + 7'd3));
                w_tdi_v = (SEQ_W'(i_cmd_data) << 3) & w_sh_v;
                w_total = CNT_W'(i_cmd_len) + CNT_W'(5);
                w_err   = !r_tap_known || (i_cmd_len == '0) || (int'(i_cmd_len) > MAX_LEN);
            end
            default: begin
                w_total = CNT_W'(i_cmd_len);
                w_empty = (i_cmd_len == '0);
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RST;
            r_cmd       <= CMD_TAP_RESET;
            r_tap_known <= 1'b0;
            r_left      <= '0;
            r_bit       <= '0;
            r_tms_sr    <= '0;
            r_tdi_sr    <= '0;
            r_sh_sr     <= '0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_sh        <= 1'b0;
            r_rx        <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
            r_trst_sr   <= '0;
            r_trst_n    <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_RST: begin
                    r_state <= ST_IDLE;
`ifdef JTAG_HOST_TRST_EN
                    r_trst_n <= 1'b1;
`endif
                end
                ST_IDLE: if (i_cmd_valid) begin
                    r_cmd <= cmd_e'(i_cmd_type);
                    r_rx  <= '0;
                    r_bit <= '0;
                    if (w_err || w_empty) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_data  <= '0;
                    end else begin
                        r_state  <= ST_RUN;
                        r_left   <= w_total;
                        r_tms    <= w_tms_v[0];
                        r_tdi    <= w_tdi_v[0];
                        r_sh     <= w_sh_v[0];
                        r_tms_sr <= w_tms_v >> 1;
                        r_tdi_sr <= w_tdi_v >> 1;
                        r_sh_sr  <= w_sh_v >> 1;
`ifdef JTAG_HOST_TRST_EN
                        r_trst_n  <= ~w_trst_v[0];
                        r_trst_sr <= w_trst_v >> 1;
`endif
                    end
                end
                ST_RUN: begin
                    if (w_rise && r_sh) begin
                        r_rx[r_bit] <= i_tdo;
                        r_bit       <= r_bit + BIT_W'(1);
                    end
                    if (w_fall) begin
                        r_tms    <= r_tms_sr[0];
                        r_tdi    <= r_tdi_sr[0];
                        r_sh     <= r_sh_sr[0];
                        r_tms_sr <= r_tms_sr >> 1;
                        r_tdi_sr <= r_tdi_sr >> 1;
                        r_sh_sr  <= r_sh_sr >> 1;
                        r_left   <= r_left - CNT_W'(1);
`ifdef JTAG_HOST_TRST_EN
                        r_trst_n  <= ~r_trst_sr[0];
                        r_trst_sr <= r_trst_sr >> 1;
`endif
                        if (r_left == CNT_W'(1)) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_data  <= r_rx;
                            if (r_cmd == CMD_TAP_RESET) r_tap_known <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_host_master.sv
// Bench for jtag_host_master: behavioural TAP (32-bit user DR at IR=0x03), response
// scoreboard drained by a negedge monitor, TCK-edge log of tms/tdi.
module tb_jtag_host_master;
    localparam int CLK_DIV = 4;
    localparam int MAX_LEN = 64;

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi, tdo, trst_n;
    logic [1:0]  cmd_type;
    logic [6:0]  cmd_len;
    logic [63:0] cmd_data, rsp_data;

    always #5 clk = ~clk;

    jtag_host_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .IR_LEN(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_type(cmd_type), .i_cmd_len(cmd_len), .i_cmd_data(cmd_data),
        .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_data(rsp_data), .o_busy(busy),
        .o_tck(tck), .o_tms(tms), .o_tdi(tdi),
`ifdef JTAG_HOST_TRST_EN
        .o_trst_n(trst_n),
`endif
        .i_tdo(tdo)
    );
`ifndef JTAG_HOST_TRST_EN
    assign trst_n = 1'b1;
`endif

    // Behavioural TAP controller
    typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                              SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_e;
    tap_e ts = TLR;
    logic [5:0]  ir = 6'h09, ir_sr = 6'h0;
    logic [31:0] dr_sr = 32'h0, dr_upd = 32'h0;
    initial tdo = 1'b0;

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) ts <= TLR;
        else begin
            case (ts)
                TLR:  ir <= 6'h09;
                CDR:  dr_sr <= (ir == 6'h03) ? 32'h00005071 : 32'h0;
                SHDR: dr_sr <= (ir == 6'h03) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
                UDR:  if (ir == 6'h03) dr_upd <= dr_sr;
                CIR:  ir_sr <= 6'b000001;
                SHIR: ir_sr <= {tdi, ir_sr[5:1]};
                UIR:  ir <= ir_sr;
                default: ;
            endcase
            case (ts)
                TLR:  ts <= tms ? TLR  : RTI;
                RTI:  ts <= tms ? SDR  : RTI;
                SDR:  ts <= tms ? SIR  : CDR;
                CDR:  ts <= tms ? E1DR : SHDR;
                SHDR: ts <= tms ? E1DR : SHDR;
                E1DR: ts <= tms ? UDR  : PDR;
                PDR:  ts <= tms ? E2DR : PDR;
                E2DR: ts <= tms ? UDR  : SHDR;
                UDR:  ts <= tms ? SDR  : RTI;
                SIR:  ts <= tms ? TLR  : CIR;
                CIR:  ts <= tms ? E1IR : SHIR;
                SHIR: ts <= tms ? E1IR : SHIR;
                E1IR: ts <= tms ? UIR  : PIR;
                PIR:  ts <= tms ? E2IR : PIR;
                E2IR: ts <= tms ? UIR  : SHIR;
                default: ts <= tms ? SDR : RTI;
            endcase
        end
    end
    always @(negedge tck) tdo <= (ts == SHDR) ? dr_sr[0] : (ts == SHIR) ? ir_sr[0] : 1'b0;

    // TCK edge log
    logic [511:0] tms_log = '0, tdi_log = '0;
    int tck_cnt = 0;
    always @(posedge tck) begin
        if (tck_cnt < 512) begin
            tms_log[tck_cnt] <= tms;
            tdi_log[tck_cnt] <= tdi;
        end
        tck_cnt <= tck_cnt + 1;
    end
    int trst_lo = 0;
    always @(negedge clk) if (!rst && !trst_n) trst_lo <= trst_lo + 1;

    // Scoreboard
    typedef struct { logic err; logic [63:0] data; } rsp_t;
    typedef struct { string name; logic [63:0] got; logic [63:0] exp; } chk_t;
    rsp_t exp_q[$];
    chk_t chk_q[$];
    int n_checks = 0, n_fail = 0;

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            n_checks++;
            if (c.got !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.name, c.got, c.exp);
            end
        end
        if (rsp_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got err=%b data=%h expected no response", rsp_err, rsp_data);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if (rsp_err !== e.err || rsp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp: got err=%b data=%h expected err=%b data=%h",
                             rsp_err, rsp_data, e.err, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_t c;
        c.name = name; c.got = got; c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_rsp(input logic err, input logic [63:0] data);
        rsp_t e;
        e.err = err; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d);
        int n = 0;
        cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk("accept_timeout", 64'(n), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() > 0 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk("rsp_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [63:0] slice(input logic [511:0] v, input int base, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n && i < 64; i++) r[i] = v[base + i];
        return r;
    endfunction

    task automatic chk_seq(input string name, input int base, input int n,
                           input logic [63:0] etms, input logic [63:0] etdi);
        chk({name, "_tcks"}, 64'(tck_cnt - base), 64'(n));
        chk({name, "_tms"}, slice(tms_log, base, n), etms);
        chk({name, "_tdi"}, slice(tdi_log, base, n), etdi);
    endtask

    int base, tl, n;
    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_len = 7'd0; cmd_data = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({cmd_ready, busy, rsp_valid, rsp_err, tck, tms, tdi}), 64'b0100010);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 64'({cmd_ready, busy}), 64'b10);
        chk("rsp_data_reset", rsp_data, 64'd0);

        // Scans before any TAP reset are rejected without toggling TCK
        base = tck_cnt;
        expect_rsp(1'b1, 64'd0); send(2'd2, 7'd32, 64'h00010000);
        chk("err_latency", 64'(rsp_valid), 64'd1);
        wait_done();
        expect_rsp(1'b1, 64'd0); send(2'd2, 7'd0, 64'd0);
        wait_done();
        chk("err_no_tck", 64'(tck_cnt - base), 64'd0);

        base = tck_cnt; tl = trst_lo;
        expect_rsp(1'b0, 64'd0); send(2'd0, 7'd0, 64'd0);
        wait_done();
        chk_seq("tap_reset", base, 6, 64'b011111, 64'd0);
        chk("tap_state", 64'(ts), 64'(RTI));
`ifdef JTAG_HOST_TRST_EN
        chk("trst_low_cycles", 64'(trst_lo - tl), 64'(4 * CLK_DIV));
`endif

        base = tck_cnt;
        expect_rsp(1'b0, 64'h01); send(2'd1, 7'd0, 64'h03);
        wait_done();
        chk_seq("ir_scan", base, 12, 64'b011000000011, 64'b000000110000);
        chk("model_ir", 64'(ir), 64'h03);

        base = tck_cnt;
        expect_rsp(1'b0, 64'h00005071); send(2'd2, 7'd32, 64'h00010000);
        wait_done();
        chk_seq("dr_scan32", base, 37, 64'h0000000C00000001, 64'h0000000000080000);
        chk("model_dr", 64'(dr_upd), 64'h00010000);

        base = tck_cnt;
        expect_rsp(1'b0, 64'd0); send(2'd3, 7'd5, 64'hFFFF);
        wait_done();
        chk_seq("rti5", base, 5, 64'd0, 64'd0);

        base = tck_cnt;
        expect_rsp(1'b0, 64'd0); send(2'd3, 7'd0, 64'd0);
        chk("rti0_latency", 64'(rsp_valid), 64'd1);
        wait_done();
        chk("rti0_no_tck", 64'(tck_cnt - base), 64'd0);

        // Back-to-back: second command is held on cmd_valid while busy
        base = tck_cnt;
        expect_rsp(1'b0, 64'd0);  send(2'd3, 7'd3, 64'd0);
        expect_rsp(1'b0, 64'h71); send(2'd2, 7'd8, 64'hA5);
        wait_done();
        chk_seq("b2b", base, 16, 64'h6008, 64'h2940);
        chk("model_dr8", 64'(dr_upd), 64'hA5000050);

        // Reset at the 10th shift TCK of a 32-bit DR scan aborts without response
        base = tck_cnt; n = 0;
        send(2'd2, 7'd32, 64'hDEADBEEF);
        while (tck_cnt - base < 13 && n < 2000) begin @(negedge clk); n++; end
        chk("abort_reach", 64'(tck_cnt - base), 64'd13);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs", 64'({tck, tms, tdi, rsp_valid, cmd_ready}), 64'b01000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        base = tck_cnt;
        expect_rsp(1'b1, 64'd0); send(2'd2, 7'd32, 64'h1);
        wait_done();
        chk("post_abort_no_tck", 64'(tck_cnt - base), 64'd0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
